// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - 32-bit signed restoring divider, one quotient bit per clock
module sequential_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [31:0] part;
  logic        sign_q;
  logic        sign_r;

  logic [31:0] x_mag;
  logic [31:0] y_mag;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] part_next;
  logic [31:0] quo_next;

  // Magnitudes are unsigned, so 0x80000000 maps cleanly to 2^31.
  always_comb begin
    x_mag     = x[31] ? (~x + 32'd1) : x;
    y_mag     = y[31] ? (~y + 32'd1) : y;
    shifted   = {part, dvd[31]};
    diff      = shifted - {1'b0, dvs};
    q_bit     = ~diff[32];
    part_next = q_bit ? diff[31:0] : shifted[31:0];
    quo_next  = {quo[30:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      part        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (y == 32'd0) begin
              quotient    <= 32'hFFFF_FFFF;
              remainder   <= x;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              dvd         <= x_mag;
              dvs         <= y_mag;
              quo         <= '0;
              part        <= '0;
              cnt         <= 5'd31;
              sign_q      <= x[31] ^ y[31];
              sign_r      <= x[31];
              state       <= RUN;
            end
          end
        end
        RUN: begin
          part <= part_next;
          quo  <= quo_next;
          dvd  <= {dvd[30:0], 1'b0};
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            quotient  <= sign_q ? (~quo_next + 32'd1) : quo_next;
            remainder <= sign_r ? (~part_next + 32'd1) : part_next;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - scoreboard bench for sequential_divider
module tb_sequential_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  sequential_divider dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .quotient(quotient), .remainder(remainder), .busy(busy),
    .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t scb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      e.q = q[31:0]; e.r = r[31:0]; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, input int abort_at);
    int   lat;
    int   n_done;
    exp_t e;
    lat = 0;
    while (busy && lat < 80) begin @(negedge clk); lat++; end
    check("idle_before_start", {31'b0, busy}, 32'd0);
    x = a; y = b; start = 1'b1;
    if (abort_at == 0) scb.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0; x = $urandom; y = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == inject_at) begin
        x = 32'd9; y = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      if (lat == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_flags", {29'b0, busy, done, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        repeat (40) begin @(negedge clk); if (done) n_done++; end
        check("no_done_after_abort", 32'(n_done), 32'd0);
        return;
      end
    end while (!done && lat < 40);
    check("latency", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
    check("busy_with_done", {31'b0, busy}, 32'd1);
    if (scb.size() != 0) begin
      e = scb.pop_front();
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
      if (b != 32'd0) check("identity", quotient * b + remainder, a);
    end else begin
      check("scoreboard_depth", 32'(scb.size()), 32'd1);
    end
  endtask

  initial begin
    int          n_done;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_flags", {29'b0, busy, done, div_by_zero}, 32'd0);
    rst = 1'b1;

    run_div(32'd100, 32'd7, 0, 0);
    run_div(32'hFFFF_FF9C, 32'd7, 0, 0);
    run_div(32'd100, 32'hFFFF_FFF9, 0, 0);
    run_div(32'd7, 32'd0, 0, 0);
    run_div(32'd9, 32'd3, 0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_div(32'h8000_0000, 32'd1, 0, 0);
    run_div(32'd0, 32'd5, 0, 0);
    run_div(32'd5, 32'h8000_0000, 0, 0);
    run_div(32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
    run_div(32'h8000_0000, 32'd0, 0, 0);

    run_div(32'd50, 32'd5, 10, 0);
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    check("ignored_start_no_done", 32'(n_done), 32'd0);
    run_div(32'd50, 32'd5, 0, 20);

    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) begin
        b = 32'($urandom_range(1, 255));
        if (a[0]) b = ~b + 32'd1;
      end
      if (b == 32'd0) b = 32'd1;
      run_div(a, b, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
